// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among NUM_REQ byte sources.
// A byte is accepted only while tx_ready is high and loads one cycle later; a stalled owner keeps its grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   tx_load,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, LOAD, WAIT} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        ptr, ptr_nxt;
    logic [PW-1:0]        gidx, gidx_nxt;
    logic [HW-1:0]        hold_cnt, hold_nxt;
    logic                 last_flag, last_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic                 tx_load_nxt;
    logic [7:0]           tx_data_nxt;

    logic                 win_vld;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        cand;

    logic                 g_vld;
    logic                 g_last;
    logic [7:0]           g_dat;

    assign g_vld  = req_valid[gidx];
    assign g_last = req_last[gidx];
    assign g_dat  = req_data[{gidx, 3'b000} +: 8];

    // Walk downwards so the candidate closest after ptr is the one left standing.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == SEND) begin
            req_ready[gidx] = g_vld & tx_ready;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gidx_nxt    = gidx;
        grant_nxt   = grant;
        hold_nxt    = hold_cnt;
        last_nxt    = last_flag;
        tx_load_nxt = 1'b0;
        tx_data_nxt = tx_data;

        case (state)
            IDLE: begin
                if (win_vld) begin
                    gidx_nxt  = win_idx;
                    grant_nxt = NUM_REQ'(1) << win_idx;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (g_vld) begin
                    if (tx_ready) begin
                        tx_data_nxt = g_dat;
                        tx_load_nxt = 1'b1;
                        last_nxt    = g_last;
                        hold_nxt    = '0;
                        state_nxt   = LOAD;
                    end
                end else if (HOLD_CYCLES != 0) begin
                    if (int'(hold_cnt) + 1 >= HOLD_CYCLES) begin
                        ptr_nxt   = gidx;
                        grant_nxt = '0;
                        hold_nxt  = '0;
                        state_nxt = IDLE;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
            end
            // Guard cycle: the transmitter has not yet dropped tx_ready for this load.
            LOAD: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_ready) begin
                    if (last_flag) begin
                        ptr_nxt   = gidx;
                        grant_nxt = '0;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            ptr       <= PW'(NUM_REQ - 1);
            gidx      <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            last_flag <= 1'b0;
            tx_load   <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gidx      <= gidx_nxt;
            grant     <= grant_nxt;
            busy      <= (state_nxt != IDLE);
            hold_cnt  <= hold_nxt;
            last_flag <= last_nxt;
            tx_load   <= tx_load_nxt;
            tx_data   <= tx_data_nxt;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among several byte-stream requesters. Each requester offers bytes on a valid/ready handshake and marks packet ends with a last flag. The arbiter locks the grant for a whole packet and issues single-cycle load pulses to the transmitter only when it reports ready. It sits between the console/debug sources and the UART transmitter's tx_load/tx_data/tx_ready port.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- HOLD_CYCLES, 1024: consecutive idle cycles of the granted requester mid-packet before the grant is forcibly released; 0 disables the timeout.
- clk  input  1  clock.
- nrst  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of its packet.
- req_ready  output  NUM_REQ  byte accepted this cycle; combinational.
- grant  output  NUM_REQ  one-hot current owner, all-zero when idle; registered.
- busy  output  1  grant held or a byte is in flight; registered.
- tx_load  output  1  one-cycle load strobe to the transmitter; registered.
- tx_data  output  8  byte to the transmitter, valid with tx_load and held after; registered.
- tx_ready  input  1  transmitter idle; drops the cycle after tx_load and rises when the frame completes.

## Operation
- States: IDLE, SEND, LOAD, WAIT. Round-robin pointer ptr (index of last owner). Timeout counter hold_cnt, width $clog2(HOLD_CYCLES+1).
- IDLE: if any req_valid, winner is the first set bit searching ptr+1, ptr+2, ... mod NUM_REQ. Register grant to the winner's one-hot bit and go to SEND. If none is set, stay.
- SEND: req_ready[g] = req_valid[g] & tx_ready, where g is the granted index. All other req_ready bits are 0.
  - On accept: register tx_data <= req_data[g], tx_load <= 1, and store last_flag <= req_last[g]. Go to LOAD and clear hold_cnt.
  - If req_valid[g] is low: increment hold_cnt. When it reaches HOLD_CYCLES (with HOLD_CYCLES != 0), release: ptr <= g, grant <= 0, go to IDLE.
  - If req_valid[g] is high but tx_ready is low: stall, and do not increment hold_cnt.
- LOAD: tx_load is high this cycle only and is cleared on exit. Go to WAIT.
- WAIT: stay while tx_ready = 0. On tx_ready = 1:
  - If last_flag: ptr <= g, grant <= 0, go to IDLE.
  - Otherwise go to SEND with the grant unchanged.
- The LOAD cycle is a guard cycle. tx_ready is not sampled for completion until WAIT, which begins after the transmitter has registered the load.
- Non-granted requesters' valid and data are ignored while a grant is held. No byte is ever dropped or duplicated.
- busy = (state != IDLE).
- Reset (any time, including mid-frame):
  - state IDLE, ptr = NUM_REQ-1 (requester 0 has first priority), grant 0, busy 0, tx_load 0, tx_data 8'h00, hold_cnt 0, last_flag 0.
  - req_ready goes 0 combinationally.
  - A byte already in the transmitter is not aborted by this block.

## Timing
- Start from idle: valid sampled in IDLE at cycle 0. grant is registered at edge 1. req_ready is high in cycle 1 (if tx_ready = 1). tx_load is high in cycle 2.
- Back-to-back bytes in a packet: tx_ready rising is seen in WAIT at cycle n. SEND (accept) is at n+1 and tx_load at n+2, giving a 2-cycle gap from frame end to next load.
- Packet switch: last frame ends at n, IDLE at n+1, next grant at edge n+2, tx_load at n+3.
- tx_load is never high in two consecutive cycles. It is never asserted unless tx_ready was 1 in the preceding accept cycle.
- Exactly one req_ready pulse corresponds to each tx_load pulse, one cycle earlier.
- A single-byte packet (req_last = 1 on the first byte) releases after its frame.

## Test plan
- Single requester 1 sends 8'hA5 with last = 1 → grant = 4'b0010 at cycle 1, req_ready[1] in cycle 1, tx_load in cycle 2 with tx_data = 8'hA5. Grant returns to 0 after tx_ready rises.
- Requesters 0 and 2 both valid from reset with 1-byte packets 8'h11 and 8'h22 → order 0 then 2. Then requesters 0 and 2 again → order 0, 2 (round robin from ptr = 2). Each tx_data matches its source.
- Requester 3 sends a 3-byte packet 8'h01, 8'h02, 8'h03 (last on 03) while requester 0 is valid throughout → the three bytes are sent contiguously before requester 0 is granted.
- HOLD_CYCLES = 8: requester 1 sends one non-last byte, then drops valid → grant is released after 8 idle SEND cycles and requester 2 (waiting) is granted next.
- tx_ready is held low by a model for 50 cycles after a load → no second tx_load and no req_ready during the stall. The load is issued 2 cycles after tx_ready rises.
- nrst is pulsed low in WAIT mid-packet → grant, busy, and tx_load are 0 immediately, tx_data = 8'h00. After release, requester 0 is granted first.
